// File: rtl/if_pkg.sv
// Shared IF-stage types and constants for the fetch controller.
package if_pkg;

    localparam int unsigned IF_ADDR_W     = 32;
    localparam int unsigned IF_DATA_W     = 32;
    localparam logic [31:0] IF_RESET_ADDR = 32'hbfc00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: turns PC fetch requests into single SRAM-like bus
// transactions and returns the instruction word, dropping responses squashed by flush.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned              ADDR_W     = IF_ADDR_W,
    parameter int unsigned              DATA_W     = IF_DATA_W,
    parameter logic [IF_ADDR_W-1:0]     RESET_ADDR = IF_RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    output logic              fetch_stall,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic              discard;
    logic              discard_n;
    logic              accept;
    logic              deliver;
    logic [ADDR_W-1:0] addr_q;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            addr_q     <= ADDR_W'(RESET_ADDR);
            bus_req    <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_addr  <= ADDR_W'(RESET_ADDR);
        end else begin
            state      <= state_n;
            discard    <= discard_n;
            bus_req    <= (state_n == ADDR);
            inst_valid <= deliver;
            if (accept) begin
                addr_q <= pc_addr;
            end
            if (deliver) begin
                inst      <= bus_rdata;
                inst_addr <= addr_q;
            end
        end
    end

    // Next state, squash tracking and the PC hold.
    always_comb begin
        state_n     = state;
        discard_n   = discard;
        accept      = 1'b0;
        deliver     = 1'b0;
        fetch_stall = 1'b0;
        case (state)
            IDLE: begin
                fetch_stall = pc_en && !flush;
                if (pc_en && !flush) begin
                    accept  = 1'b1;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                fetch_stall = 1'b1;
                if (flush) begin
                    discard_n = 1'b1;
                end
                if (bus_addr_ok) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                fetch_stall = !(bus_data_ok && !discard && !flush);
                if (bus_data_ok) begin
                    state_n   = IDLE;
                    discard_n = 1'b0;
                    deliver   = !discard && !flush;
                end else if (flush) begin
                    discard_n = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                discard_n = 1'b0;
            end
        endcase
    end

    assign bus_addr = addr_q;

endmodule
